// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with programmable latency,
// byte/half/word lanes, little-endian word array, sign/zero-extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic        cap_we, cap_sign;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_size;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter_resp, retire;
    logic        eff_we, eff_sign;
    logic [31:0] eff_addr, eff_wdata;
    logic [1:0]  eff_size;
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, sh_word, load_ext;
    logic [3:0]  lane_en;
    logic [31:0] bit_mask, wrep, merged;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;
    assign retire     = rsp_valid && rsp_ready;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With LATENCY=1 RESP is entered on the accept edge itself, before the
    // capture registers hold the request, so the live inputs are used in IDLE.
    assign eff_we    = (state == IDLE) ? req_we    : cap_we;
    assign eff_sign  = (state == IDLE) ? req_sign  : cap_sign;
    assign eff_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign eff_size  = (state == IDLE) ? req_size  : cap_size;

    assign idx     = eff_addr[AW+1:2];
    assign rd_word = mem[idx];
    assign sh_word = rd_word >> {eff_addr[1:0], 3'b000};

    always_comb begin
        err = 1'b0;
        if (eff_size == 2'b11)                              err = 1'b1;
        if (eff_size == 2'b01 && eff_addr[0])               err = 1'b1;
        if (eff_size == 2'b10 && eff_addr[1:0] != 2'b00)    err = 1'b1;
        if ({2'b00, eff_addr[31:2]} >= DEPTH32)             err = 1'b1;
    end

    always_comb begin
        lane_en = 4'b0000;
        wrep    = eff_wdata;
        case (eff_size)
            2'b00: begin
                lane_en = 4'b0001 << eff_addr[1:0];
                wrep    = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                lane_en = 4'b0011 << {eff_addr[1], 1'b0};
                wrep    = {2{eff_wdata[15:0]}};
            end
            2'b10: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            bit_mask[i*8 +: 8] = {8{lane_en[i]}};
        end
        merged = (rd_word & ~bit_mask) | (wrep & bit_mask);
    end

    always_comb begin
        load_ext = rd_word;
        case (eff_size)
            2'b00: load_ext = eff_sign ? {{24{sh_word[7]}}, sh_word[7:0]}
                                       : {24'b0, sh_word[7:0]};
            2'b01: load_ext = eff_sign ? {{16{sh_word[15]}}, sh_word[15:0]}
                                       : {16'b0, sh_word[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_sign  <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_size  <= 2'b00;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_we    <= req_we;
                cap_sign  <= req_sign;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_size  <= req_size;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= err;
                rsp_rdata <= (err || eff_we) ? 32'd0 : load_ext;
            end else if (retire) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Array is deliberately not reset; a store commits only on the edge into RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_we && !err) begin
            mem[idx] <= merged;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders at LATENCY 2, 4 and 1 sharing clock and reset.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [1:0]  req_size  [3];
    logic        req_sign  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk(clk), .rstn(rstn),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_addr(req_addr[g]), .req_size(req_size[g]),
            .req_sign(req_sign[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]), .busy(busy[g])
        );
    end

    // One full transaction with rsp_ready high; lat counts the accept edge as 1.
    task automatic xfer(input int k, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit sign, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we[k] = we; req_addr[k] = addr; req_size[k] = size;
        req_sign[k] = sign; req_wdata[k] = wdata; req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'd0 ||
                rsp_err[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k], busy[k]);
            end
        end
    endtask

    task automatic test_word_and_half();
        logic [31:0] rd; logic e; int lat;
        xfer(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, rd, e, lat);
        checks++;
        if (lat !== 2 || rd !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL store_word lat=%0d rdata=%h err=%b, want 2 0 0", lat, rd, e);
        end
        xfer(0, 0, 32'h10, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL load_word lat=%0d rdata=%h err=%b, want 2 deadbeef 0", lat, rd, e);
        end
        xfer(0, 1, 32'h12, 2'b01, 0, 32'h0000BEEF, rd, e, lat);
        xfer(0, 0, 32'h10, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hBEEFBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL half_merge rdata=%h err=%b, want beefbeef 0", rd, e);
        end
        xfer(0, 0, 32'h12, 2'b01, 1, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFFBEEF) begin
            errors++;
            $display("FAIL load_half_signed rdata=%h, want ffffbeef", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic e; int lat;
        xfer(0, 1, 32'h20, 2'b10, 0, 32'h00000000, rd, e, lat);
        xfer(0, 1, 32'h23, 2'b00, 0, 32'h00000080, rd, e, lat);
        xfer(0, 0, 32'h23, 2'b00, 1, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_signed rdata=%h err=%b, want ffffff80 0", rd, e);
        end
        xfer(0, 0, 32'h23, 2'b00, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL load_byte_zero rdata=%h, want 00000080", rd);
        end
        xfer(0, 0, 32'h20, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h80000000) begin
            errors++;
            $display("FAIL byte_merge_word rdata=%h, want 80000000", rd);
        end
        xfer(0, 0, 32'h22, 2'b01, 1, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL load_half_upper rdata=%h, want ffff8000", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        xfer(0, 0, 32'h21, 2'b01, 0, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_half err=%b rdata=%h, want 1 0", e, rd);
        end
        xfer(0, 1, 32'h22, 2'b10, 0, 32'h11223344, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_word_store err=%b rdata=%h, want 1 0", e, rd);
        end
        xfer(0, 0, 32'h20, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h80000000 || e !== 1'b0) begin
            errors++;
            $display("FAIL error_store_no_write rdata=%h err=%b, want 80000000 0", rd, e);
        end
        xfer(0, 0, 32'h1000, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL out_of_range err=%b rdata=%h, want 1 0", e, rd);
        end
        xfer(0, 0, 32'h20, 2'b11, 0, 32'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL illegal_size err=%b rdata=%h, want 1 0", e, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic e; int lat;
        xfer(0, 1, 32'h30, 2'b10, 0, 32'h5A5AA5A5, rd, e, lat);
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        req_we[0] = 1'b0; req_addr[0] = 32'h32; req_size[0] = 2'b01;
        req_sign[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        // A competing store held valid while the responder is busy must be ignored.
        req_we[0] = 1'b1; req_addr[0] = 32'h30; req_size[0] = 2'b10;
        req_wdata[0] = 32'hFFFFFFFF;
        lat = 1;
        while (!rsp_valid[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2 || rsp_rdata[0] !== 32'h00005A5A || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_first lat=%0d rdata=%h err=%b, want 2 00005a5a 0",
                     lat, rsp_rdata[0], rsp_err[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h00005A5A ||
                rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: vld=%b rdata=%h err=%b rdy=%b, want 1 00005a5a 0 0",
                         c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
            end
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release vld=%b busy=%b, want 0 0", rsp_valid[0], busy[0]);
        end
        xfer(0, 0, 32'h30, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h5A5AA5A5) begin
            errors++;
            $display("FAIL bp_ignored_store rdata=%h, want 5a5aa5a5", rd);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic e; int lat;
        xfer(1, 1, 32'h40, 2'b10, 0, 32'hCAFEF00D, rd, e, lat);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            errors++;
            $display("FAIL lat4_store lat=%0d err=%b, want 4 0", lat, e);
        end
        @(negedge clk);
        req_we[1] = 1'b1; req_addr[1] = 32'h40; req_size[1] = 2'b10;
        req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 ||
            rsp_err[1] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1], busy[1]);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        xfer(1, 0, 32'h40, 2'b10, 0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || lat !== 4) begin
            errors++;
            $display("FAIL store_discarded rdata=%h lat=%0d, want cafef00d 4", rd, lat);
        end
    endtask

    task automatic apply_b2b(input int i);
        req_we[2]    = (i < 4);
        req_addr[2]  = 32'h80 + 32'(4 * (i % 4));
        req_size[2]  = 2'b10;
        req_sign[2]  = 1'b0;
        req_wdata[2] = 32'((i % 4) + 1) * 32'h01010101;
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int rsp_idx = 0;
        logic acc;
        logic [31:0] exp_d;
        apply_b2b(0);
        req_valid[2] = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            acc = req_ready[2] && req_valid[2];
            checks++;
            if (busy[2] !== logic'(cyc % 2) || acc !== logic'(cyc % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_pattern cycle %0d: busy=%b accept=%b, want %0d %0d",
                         cyc, busy[2], acc, cyc % 2, (cyc % 2 == 0));
            end
            @(posedge clk); #1;
            if (rsp_valid[2]) begin
                exp_d = (rsp_idx < 4) ? 32'd0 : 32'(rsp_idx - 3) * 32'h01010101;
                checks++;
                if (rsp_rdata[2] !== exp_d || rsp_err[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data req %0d: rdata=%h err=%b, want %h 0",
                             rsp_idx, rsp_rdata[2], rsp_err[2], exp_d);
                end
                rsp_idx++;
            end
            if (acc) begin
                idx++;
                if (idx < 8) apply_b2b(idx);
                else req_valid[2] = 1'b0;
            end
        end
        checks++;
        if (rsp_idx !== 8) begin
            errors++;
            $display("FAIL b2b_count responses=%0d, want 8", rsp_idx);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'd0;
            req_size[k] = 2'b10; req_sign[k] = 1'b0; req_wdata[k] = 32'd0;
            rsp_ready[k] = 1'b1;
        end
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        test_word_and_half();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the 5-stage pipeline core. It is the memory side of the core's load/store port and serves one request at a time over a valid/ready request channel and a valid/ready response channel. It supports byte, half and word accesses with programmable latency, so the core's Mem-stage stall logic can be exercised. Storage is little-endian and word-organised; the block performs lane merging on stores and sign/zero extension on loads.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[31:2].
LATENCY, 2, number of cycles from the request-accept edge to rsp_valid high; legal range 1..15.

Ports:
clk  input  1  clock.
rstn  input  1  reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  output  1  response present.
rsp_ready  input  1  core accepts the response.
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
rsp_err  output  1  misaligned, illegal size or out-of-range access.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. On reset assertion the state goes to IDLE, the latency counter clears, and the captured request is cleared.
  - Output reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we, addr, size, sign and wdata. Go to WAIT if LATENCY > 1, else go to RESP.
  - WAIT: the counter is loaded with LATENCY-1 on accept and decrements each cycle. Go to RESP when the counter reaches 1, so rsp_valid rises exactly LATENCY edges after the accept edge.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid on the next edge.
- req_ready is 0 in WAIT and RESP. There is no back-to-back overlap: minimum request spacing is LATENCY+1 cycles when rsp_ready is tied high.
- Error detection, evaluated on the captured request:
  - size 11 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - An error store does not modify the array. An error response has rsp_err = 1 and rsp_rdata = 0.
- Store commit: the array write happens on the edge that enters RESP, never earlier.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Word: the full word is written.
  - Untouched lanes keep their value. Store response: rsp_rdata = 0, rsp_err = 0.
- Load: the word is read at the edge entering RESP and registered.
  - Lane extraction follows addr[1:0].
  - Bit 7 (byte) or bit 15 (half) is replicated when sign = 1; zero fill otherwise.
- Read-after-write: a load accepted after a store's response sees the stored data. No bypass is needed because requests never overlap.
- Reset mid-operation: a store whose FSM has not yet entered RESP is discarded (array unchanged). A response pending in RESP is dropped (rsp_valid = 0).
- req_valid while not ready is ignored. The core must hold the request stable until accepted; the responder must not sample it early.
- rsp_ready high in IDLE or WAIT has no effect.

Test Plan:
1. LATENCY=2: store word 0xDEADBEEF to 0x10, then load word 0x10 -> rsp_valid exactly 2 edges after each accept; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
2. Word 0x00000000 at 0x20, then store byte 0x80 at 0x23:
   - load byte 0x23 with sign=1 -> 0xFFFFFF80.
   - same load with sign=0 -> 0x00000080.
   - load word 0x20 -> 0x80000000.
3. Load half at 0x21 -> rsp_err = 1, rsp_rdata = 0. Store word at 0x22 -> rsp_err = 1 and a following load word 0x20 is unchanged. Address 4*DEPTH_WORDS -> rsp_err = 1.
4. Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant, req_ready = 0, and a new req_valid is not accepted; on release the response retires in 1 cycle.
5. LATENCY=4: store word 0x12345678 to 0x40, assert rstn low 2 cycles after accept -> outputs at reset values; a later load of 0x40 returns the prior contents, not 0x12345678.
6. LATENCY=1 with rsp_ready tied high and 8 back-to-back requests -> one accept every 2 cycles; busy pattern 1,0 repeating; all data correct.
